// File: rtl/noc_router_tile.sv
`default_nettype none
// ============================================================================
// Module   : noc_router_tile
// Purpose  : Clocked five-port mesh router tile (N, E, S, W, Local) with one
//            FIFO per input, Y-first routing, a round-robin arbiter per
//            output and a registered output stage. Request flits addressed
//            to this tile pass through an ALU and leave as response flits.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid/ready  - per-input handshake (0=N 1=E 2=S 3=W 4=L)
//            in_a/b/ctrl     - packed input flit fields, port p at slice p
//            out_valid/ready - per-output handshake
//            out_a/b/ctrl    - packed registered output flit fields
//            drop_cnt        - saturating count of flits with off-mesh dst
// Revision : 1.0 - initial clocked release
// ============================================================================
module noc_router_tile #(
    parameter int TILE_X     = 0,
    parameter int TILE_Y     = 0,
    parameter int GRID_X     = 3,
    parameter int GRID_Y     = 3,
    parameter int DATA_W     = 64,
    parameter int COORD_W    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          in_valid,
    output logic [4:0]          in_ready,
    input  logic [5*DATA_W-1:0] in_a,
    input  logic [5*DATA_W-1:0] in_b,
    input  logic [5*16-1:0]     in_ctrl,
    output logic [4:0]          out_valid,
    input  logic [4:0]          out_ready,
    output logic [5*DATA_W-1:0] out_a,
    output logic [5*DATA_W-1:0] out_b,
    output logic [5*16-1:0]     out_ctrl,
    output logic [15:0]         drop_cnt
);

    // Flit packing inside the tile: {ctrl, b, a}
    localparam int c_flit_w   = 2 * DATA_W + 16;
    localparam int c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w    = c_ptr_w + 1;
    localparam int c_sh_w     = $clog2(DATA_W);
    localparam int c_resp_bit = 4 + 2 * COORD_W;
    localparam int unsigned c_tx = TILE_X;
    localparam int unsigned c_ty = TILE_Y;
    localparam int unsigned c_gx = GRID_X;
    localparam int unsigned c_gy = GRID_Y;
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(FIFO_DEPTH);

    localparam logic [2:0] c_port_n = 3'd0;
    localparam logic [2:0] c_port_e = 3'd1;
    localparam logic [2:0] c_port_s = 3'd2;
    localparam logic [2:0] c_port_w = 3'd3;
    localparam logic [2:0] c_port_l = 3'd4;
    // Responses always head back toward (0,0): north first, then west.
    localparam logic [2:0] c_resp_port = (TILE_Y > 0) ? c_port_n :
                                         (TILE_X > 0) ? c_port_w : c_port_l;

    function automatic logic [DATA_W-1:0] f_alu(input logic [3:0] mode,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [c_sh_w-1:0] sh;
        sh = b[c_sh_w-1:0];
        case (mode)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return (b == '0) ? '0 : a / b;
            4'd4:    return a & b;
            4'd5:    return a | b;
            4'd6:    return a ^ b;
            4'd7:    return a << sh;
            4'd8:    return a >> sh;
            default: return '0;
        endcase
    endfunction

    function automatic logic [15:0] f_resp_ctrl(input logic [3:0] mode);
        logic [15:0] c;
        c             = '0;
        c[3:0]        = mode;
        c[c_resp_bit] = 1'b1;
        return c;
    endfunction

    // Index of the k-th port after base, wrapping modulo 5
    function automatic logic [2:0] f_wrap(input logic [2:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= 5) s = s - 5;
        return 3'(s);
    endfunction

    logic [4:0]                 w_drop;
    logic [4:0]                 w_pop;
    logic [4:0][4:0]            w_route;     // [input][output] one-hot request
    logic [4:0][c_flit_w-1:0]   w_xflit;     // head flit as it will leave
    logic [4:0]                 w_free;
    logic [4:0]                 w_gnt_valid;
    logic [4:0][2:0]            w_gnt_idx;
    logic [2:0]                 w_drop_num;
    logic [16:0]                w_drop_sum;

    logic [4:0]                 r_out_valid;
    logic [4:0][c_flit_w-1:0]   r_out_flit;
    logic [4:0][2:0]            r_rr_ptr;
    logic [15:0]                r_drop_cnt;

    // ------------------------------------------------------------------
    // Per-input FIFO and head-of-line route decision
    // ------------------------------------------------------------------
    for (genvar p = 0; p < 5; p++) begin : g_port
        logic [c_flit_w-1:0] r_mem [FIFO_DEPTH];
        logic [c_ptr_w-1:0]  r_rd_ptr;
        logic [c_ptr_w-1:0]  r_wr_ptr;
        logic [c_cnt_w-1:0]  r_count;
        logic                w_full;
        logic                w_push;
        logic                w_nonempty;
        logic [c_flit_w-1:0] w_head;
        logic [DATA_W-1:0]   w_a;
        logic [DATA_W-1:0]   w_b;
        logic [3:0]          w_mode;
        logic [COORD_W-1:0]  w_dx;
        logic [COORD_W-1:0]  w_dy;
        logic                w_is_resp;
        logic                w_fwd;
        logic                w_drop_l;
        logic [2:0]          w_dest;
        logic [c_flit_w-1:0] w_xf;

        // A full FIFO refuses even when it pops this cycle; keeps in_ready
        // independent of the arbiter.
        assign w_full      = (r_count == c_cnt_full);
        assign in_ready[p] = ~rst & ~w_full;
        assign w_push      = in_valid[p] & in_ready[p];
        assign w_nonempty  = (r_count != '0);

        always_ff @(posedge clk) begin
            if (w_push)
                r_mem[r_wr_ptr] <= {in_ctrl[p*16 +: 16], in_b[p*DATA_W +: DATA_W],
                                    in_a[p*DATA_W +: DATA_W]};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push)   r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                if (w_pop[p]) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop[p]);
            end
        end

        assign w_head    = r_mem[r_rd_ptr];
        assign w_a       = w_head[DATA_W-1:0];
        assign w_b       = w_head[2*DATA_W-1:DATA_W];
        assign w_mode    = w_head[2*DATA_W +: 4];
        assign w_dy      = w_head[2*DATA_W + 4 +: COORD_W];
        assign w_dx      = w_head[2*DATA_W + 4 + COORD_W +: COORD_W];
        assign w_is_resp = w_head[2*DATA_W + c_resp_bit];

        always_comb begin
            w_drop_l = 1'b0;
            w_fwd    = 1'b0;
            w_dest   = c_port_l;
            w_xf     = w_head;
            if (w_nonempty) begin
                // Off-mesh destinations are discarded before any routing.
                if (32'(w_dx) >= c_gx || 32'(w_dy) >= c_gy) begin
                    w_drop_l = 1'b1;
                end else begin
                    w_fwd = 1'b1;
                    if (w_is_resp) begin
                        w_dest = c_resp_port;
                    end else if (32'(w_dy) > c_ty) begin
                        w_dest = c_port_s;
                    end else if (32'(w_dy) < c_ty) begin
                        w_dest = c_port_n;
                    end else if (32'(w_dx) > c_tx) begin
                        w_dest = c_port_e;
                    end else if (32'(w_dx) < c_tx) begin
                        w_dest = c_port_w;
                    end else begin
                        // Request for this tile: turn it into a response.
                        w_dest = c_resp_port;
                        w_xf   = {f_resp_ctrl(w_mode), {DATA_W{1'b0}},
                                  f_alu(w_mode, w_a, w_b)};
                    end
                end
            end
        end

        assign w_drop[p]  = w_drop_l;
        assign w_xflit[p] = w_xf;
        assign w_route[p] = w_fwd ? (5'b00001 << w_dest) : 5'b00000;
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration: one grant per free output register
    // ------------------------------------------------------------------
    assign w_free = ~r_out_valid | out_ready;

    always_comb begin
        w_gnt_valid = '0;
        w_gnt_idx   = '0;
        w_pop       = w_drop;
        for (int o = 0; o < 5; o++) begin
            if (w_free[o]) begin
                for (int k = 0; k < 5; k++) begin
                    if (!w_gnt_valid[o] && w_route[f_wrap(r_rr_ptr[o], k)][o]) begin
                        w_gnt_valid[o]                   = 1'b1;
                        w_gnt_idx[o]                     = f_wrap(r_rr_ptr[o], k);
                        w_pop[f_wrap(r_rr_ptr[o], k)]    = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_drop_num = '0;
        for (int p = 0; p < 5; p++)
            w_drop_num = w_drop_num + 3'(w_drop[p]);
    end
    assign w_drop_sum = 17'(r_drop_cnt) + 17'(w_drop_num);

    // ------------------------------------------------------------------
    // Output registers, arbiter pointers and drop counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= '0;
            r_out_flit  <= '0;
            r_rr_ptr    <= '0;
            r_drop_cnt  <= '0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (w_gnt_valid[o]) begin
                    // Load on grant; a simultaneous drain makes this full-rate.
                    r_out_valid[o] <= 1'b1;
                    r_out_flit[o]  <= w_xflit[w_gnt_idx[o]];
                    r_rr_ptr[o]    <= (w_gnt_idx[o] == 3'd4) ? 3'd0 : w_gnt_idx[o] + 3'd1;
                end else if (out_ready[o]) begin
                    r_out_valid[o] <= 1'b0;
                end
            end
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    for (genvar o = 0; o < 5; o++) begin : g_out
        assign out_a[o*DATA_W +: DATA_W] = r_out_flit[o][DATA_W-1:0];
        assign out_b[o*DATA_W +: DATA_W] = r_out_flit[o][2*DATA_W-1:DATA_W];
        assign out_ctrl[o*16 +: 16]      = r_out_flit[o][2*DATA_W +: 16];
    end

    assign out_valid = r_out_valid;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/noc_router_tile.md
Name: noc_router_tile

Overview:
- Clocked, parametrised successor to the combinational single-packet XY tile.
- Five-port router (N, E, S, W, Local) with a per-input FIFO, a valid/ready handshake on every link, a round-robin output arbiter and a registered output stage.
- An integrated ALU turns request flits addressed to this tile into response flits.
- Instances are tiled into a GRID_X x GRID_Y mesh, so multiple packets can be in flight at once.

Parameters:
- TILE_X, 0, x coordinate of this tile.
- TILE_Y, 0, y coordinate of this tile.
- GRID_X, 3, mesh width.
- GRID_Y, 3, mesh height.
- DATA_W, 64, width of operands a and b.
- COORD_W, 2, coordinate field width; legal range 1..5.
- FIFO_DEPTH, 4, entries per input FIFO; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  5  per-port flit valid; index 0=N, 1=E, 2=S, 3=W, 4=L
- in_ready  out  5  per-port accept
- in_a  in  5*DATA_W  packed operand a, port p at [p*DATA_W +: DATA_W]
- in_b  in  5*DATA_W  packed operand b
- in_ctrl  in  5*16  packed ctrl
- out_valid  out  5  per-port output valid
- out_ready  in  5  downstream accept
- out_a  out  5*DATA_W  packed output a
- out_b  out  5*DATA_W  packed output b
- out_ctrl  out  5*16  packed output ctrl
- drop_cnt  out  16  count of dropped flits

Behaviour:
- Ctrl layout:
  - [3:0] mode.
  - [4 +: COORD_W] dst_y.
  - [4+COORD_W +: COORD_W] dst_x.
  - [4+2*COORD_W] resp.
  - Remaining bits are carried unchanged on forwarded flits and zero on generated responses.
- Reset (synchronous, rst=1 at posedge):
  - All FIFOs empty, all out_valid=0, out_a/out_b/out_ctrl=0.
  - Round-robin pointers=0, drop_cnt=0.
  - In-flight flits are discarded.
  - in_ready=0 while rst is high.
- Input side:
  - A flit is accepted when in_valid[p] & in_ready[p] at posedge.
  - in_ready[p] = !full[p]. A full FIFO does not accept even if it is popped in the same cycle.
  - Inputs are ignored when in_ready is low.
- Route of the head flit of each FIFO, Y-first:
  - Request, dst != here: dst_y>TILE_Y→S; dst_y<TILE_Y→N; else dst_x>TILE_X→E; dst_x<TILE_X→W. The flit is forwarded unchanged.
  - Request, dst == here: ALU result R. The response flit is a=R, b=0, resp=1, dst=(0,0), mode kept. It routes as a response.
  - Response: TILE_Y>0→N; else TILE_X>0→W; else→L.
  - dst_x>=GRID_X or dst_y>=GRID_Y: the head is popped and discarded, and drop_cnt increments, saturating at 16'hFFFF.
- ALU (DATA_W bits, result truncated to DATA_W):
  - 0 add, 1 sub (wrap), 2 mul (low DATA_W bits).
  - 3 div (b==0→0).
  - 4 and, 5 or, 6 xor.
  - 7 shl, 8 shr, each by b[$clog2(DATA_W)-1:0].
  - Mode 9..15→0.
- Arbitration, per output o:
  - Requesters are the non-empty inputs whose head routes to o, only while out reg o is free, i.e. !out_valid[o] | out_ready[o].
  - Grant goes to the lowest index at or above rr_ptr[o], wrapping round.
  - rr_ptr[o] becomes grant+1 mod 5, only on a grant.
  - Each input heads to exactly one output, so at most one pop per FIFO per cycle.
- Output stage:
  - The output register loads on grant; out_valid holds until out_ready.
  - Data is stable while out_valid & !out_ready.
  - Full-rate pass: load and drain happen in the same cycle.
- Latency:
  - Accept at posedge k, then flit at output register after posedge k+1, with empty FIFO and free output.
  - A FIFO can push and pop in the same cycle (when not full); count is unchanged.
  - Ordering is preserved per input→output pair.
- Edge tiles: output ports facing off-mesh are unreachable for legal destinations. Unused inputs are tied in_valid=0 by the integrator.

Test Plan:
1. Tile(1,1), GRID 3x3: L injects req dst=(1,1) mode0 a=5 b=7 → after 2 posedges out_valid[N]=1, out_a=12, out_b=0, ctrl resp=1 dst=(0,0) mode=0.
2. Tile(1,1): W input req dst=(2,2) a=3 → out[S] carries identical a/b/ctrl; then tile(0,0) gets resp on E input → exits L.
3. Backpressure, depth 4: out_ready[S]=0, W streams 6 flits to (1,2) → 5 accepted (1 out reg + 4 FIFO), in_ready[W]=0; out_ready=1 → all 5 emerge in order, one per cycle, then in_ready=1.
4. Arbitration: N and W both continuously target E → grants N,W,N,W; out_ready toggling does not reorder.
5. ALU edges: mode3 a=9 b=0 → a=0; mode7 a=1 b=65 → a=2; mode1 a=0 b=1 → all-ones; mode12 → 0.
6. L req dst_x=3 (GRID_X=3) → no output, drop_cnt=1; assert rst mid-stream with 3 flits buffered → next cycle all out_valid=0, drop_cnt=0, in_ready=1 after rst falls.
